// File: rtl/kamacore_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority; multi-cycle
// results wait in a small FIFO and take idle slots, with a forced stall on starvation.
`timescale 1ns/1ps
module kamacore_wb_arbiter #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CPU_WIDTH      = 32,
  parameter int FIFO_DEPTH     = 2,
  parameter int STARVE_LIMIT   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_rd_we,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_a,
  input  logic [CPU_WIDTH-1:0]      wb_rd_data,
  output logic                      wb_stall,
  input  logic                      mc_valid,
  output logic                      mc_ready,
  input  logic [REG_ADDR_WIDTH-1:0] mc_rd_a,
  input  logic [CPU_WIDTH-1:0]      mc_rd_data,
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_a,
  output logic [CPU_WIDTH-1:0]      rf_data,
  output logic                      fifo_empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

  logic [REG_ADDR_WIDTH-1:0] addr_mem [FIFO_DEPTH];
  logic [CPU_WIDTH-1:0]      data_mem [FIFO_DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;

  logic push;
  logic pop;
  logic wb_busy;

  // Status flags come from registered state only, so no input reaches them.
  assign fifo_empty = (count_q == '0);
  assign mc_ready   = (count_q != FULL_CNT);
  assign wb_stall   = (starve_q == STARVE_MAX) && !fifo_empty;

  assign wb_busy = wb_rd_we && (wb_rd_a != '0);
  assign push    = mc_valid && mc_ready && (mc_rd_a != '0);

  always_comb begin
    pop     = 1'b0;
    rf_we   = 1'b0;
    rf_a    = '0;
    rf_data = '0;
    if (!rst) begin
      if (wb_stall) begin
        pop = 1'b1;
      end else if (wb_busy) begin
        rf_we   = 1'b1;
        rf_a    = wb_rd_a;
        rf_data = wb_rd_data;
      end else if (!fifo_empty) begin
        pop = 1'b1;
      end
      if (pop) begin
        rf_we   = 1'b1;
        rf_a    = addr_mem[rd_ptr_q];
        rf_data = data_mem[rd_ptr_q];
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + CW'(push) - CW'(pop);
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  // Storage is data only; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= mc_rd_a;
      data_mem[wr_ptr_q] <= mc_rd_data;
    end
  end

endmodule

// File: tb/tb_kamacore_wb_arbiter.sv
// Bench for kamacore_wb_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_kamacore_wb_arbiter;

  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int LIM   = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          wb_rd_we;
  logic [AW-1:0] wb_rd_a;
  logic [DW-1:0] wb_rd_data;
  logic          wb_stall;
  logic          mc_valid;
  logic          mc_ready;
  logic [AW-1:0] mc_rd_a;
  logic [DW-1:0] mc_rd_data;
  logic          rf_we;
  logic [AW-1:0] rf_a;
  logic [DW-1:0] rf_data;
  logic          fifo_empty;

  always #5 clk = ~clk;

  kamacore_wb_arbiter #(
    .REG_ADDR_WIDTH(AW), .CPU_WIDTH(DW), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIM)
  ) dut (
    .clk(clk), .rst(rst),
    .wb_rd_we(wb_rd_we), .wb_rd_a(wb_rd_a), .wb_rd_data(wb_rd_data), .wb_stall(wb_stall),
    .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_rd_a(mc_rd_a), .mc_rd_data(mc_rd_data),
    .rf_we(rf_we), .rf_a(rf_a), .rf_data(rf_data), .fifo_empty(fifo_empty)
  );

  int checks = 0;
  int errors = 0;
  bit model_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending results as a queue, plus how long the head has waited.
  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t q[$];
  int   head_wait = 0;

  always @(negedge clk) begin
    logic          e_empty, e_ready, e_stall, e_we, busy, take_head;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    if (model_on) begin
      e_empty   = (q.size() == 0);
      e_ready   = (q.size() < DEPTH);
      e_stall   = !e_empty && (head_wait >= LIM);
      busy      = wb_rd_we && (wb_rd_a != 0);
      take_head = 1'b0;
      e_we      = 1'b0;
      e_a       = '0;
      e_d       = '0;
      if (!rst) begin
        if (e_stall) take_head = 1'b1;
        else if (busy) begin
          e_we = 1'b1; e_a = wb_rd_a; e_d = wb_rd_data;
        end else if (!e_empty) take_head = 1'b1;
        if (take_head) begin
          e_we = 1'b1; e_a = q[0].a; e_d = q[0].d;
        end
      end
      chk("m_fifo_empty", fifo_empty, e_empty);
      chk("m_mc_ready", mc_ready, e_ready);
      chk("m_wb_stall", wb_stall, e_stall);
      chk("m_rf_we", rf_we, e_we);
      if (e_we) begin
        chk("m_rf_a", rf_a, e_a);
        chk("m_rf_data", rf_data, e_d);
      end
      if (rst) begin
        q.delete();
        head_wait = 0;
      end else begin
        if (take_head) begin
          void'(q.pop_front());
          head_wait = 0;
        end else if (!e_empty) begin
          head_wait++;
        end
        if (mc_valid && e_ready && mc_rd_a != 0) q.push_back({mc_rd_a, mc_rd_data});
        if (q.size() == 0) head_wait = 0;
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    wb_rd_we = 1'b0; wb_rd_a = '0; wb_rd_data = '0;
    mc_valid = 1'b0; mc_rd_a = '0; mc_rd_data = '0;
  endtask

  initial begin
    int log_a[$];
    bit acc;
    bit stall_prev;
    bit ready_checked;

    idle_inputs();
    rst = 1'b1;
    nxt();
    model_on = 1'b1;
    nxt();
    rst = 1'b0;
    smp();
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_mc_ready", mc_ready, 1);
    chk("rst_wb_stall", wb_stall, 0);
    chk("rst_rf_we", rf_we, 0);

    // Idle pipeline: push rd 3, written the following cycle.
    nxt(); mc_valid = 1; mc_rd_a = 3; mc_rd_data = 32'hDEADBEEF;
    smp(); chk("t1_no_bypass", rf_we, 0);
    nxt(); mc_valid = 0;
    smp();
    chk("t1_we", rf_we, 1);
    chk("t1_a", rf_a, 3);
    chk("t1_data", rf_data, 32'hDEADBEEF);
    nxt(); smp(); chk("t1_drained", fifo_empty, 1);

    // Priority and forced stall.
    nxt(); wb_rd_we = 1; wb_rd_a = 5; wb_rd_data = 32'h55;
    mc_valid = 1; mc_rd_a = 7; mc_rd_data = 32'h77;
    smp(); chk("t2_c0_a", rf_a, 5);
    nxt(); mc_valid = 0;
    for (int i = 1; i <= 4; i++) begin
      if (i > 1) nxt();
      smp();
      chk("t2_pipe_a", rf_a, 5);
      chk("t2_no_stall", wb_stall, 0);
    end
    nxt(); smp();
    chk("t2_stall", wb_stall, 1);
    chk("t2_head_a", rf_a, 7);
    chk("t2_head_data", rf_data, 32'h77);
    nxt(); smp();
    chk("t2_stall_drop", wb_stall, 0);
    chk("t2_pipe_back", rf_a, 5);

    // x0 handling.
    nxt(); wb_rd_we = 0; mc_valid = 1; mc_rd_a = 0; mc_rd_data = 32'h1234;
    smp();
    nxt(); mc_valid = 0;
    for (int i = 0; i < 2; i++) begin
      if (i > 0) nxt();
      smp();
      chk("t3_x0_empty", fifo_empty, 1);
      chk("t3_x0_no_we", rf_we, 0);
    end
    nxt(); mc_valid = 1; mc_rd_a = 9; mc_rd_data = 32'h99;
    smp();
    nxt(); mc_valid = 0; wb_rd_we = 1; wb_rd_a = 0; wb_rd_data = 32'hBAD;
    smp();
    chk("t3_x0slot_we", rf_we, 1);
    chk("t3_x0slot_a", rf_a, 9);
    chk("t3_x0slot_data", rf_data, 32'h99);
    nxt(); wb_rd_we = 0;
    smp(); chk("t3_empty_after", fifo_empty, 1);

    // Full / backpressure with a held third request.
    nxt(); wb_rd_we = 1; wb_rd_a = 5; wb_rd_data = 32'h55;
    mc_valid = 1; mc_rd_a = 10; mc_rd_data = 32'hA0;
    smp();
    nxt(); mc_rd_a = 11; mc_rd_data = 32'hA1;
    smp();
    nxt(); mc_rd_a = 12; mc_rd_data = 32'hA2;
    smp();
    chk("t4_full_ready", mc_ready, 0);
    if (rf_we && rf_a != 5) log_a.push_back(int'(rf_a));
    acc = mc_valid && mc_ready;
    stall_prev = wb_stall;
    ready_checked = 0;
    for (int i = 0; i < 30; i++) begin
      nxt();
      if (acc) begin
        mc_valid = 0; wb_rd_we = 0; acc = 0;
      end
      smp();
      if (rf_we && rf_a != 5) log_a.push_back(int'(rf_a));
      if (stall_prev && !ready_checked) begin
        chk("t4_ready_after_pop", mc_ready, 1);
        ready_checked = 1;
      end
      stall_prev = wb_stall;
      if (mc_valid && mc_ready) acc = 1;
    end
    chk("t4_ready_checked", ready_checked, 1);
    chk("t4_write_count", log_a.size(), 3);
    if (log_a.size() == 3) begin
      for (int i = 0; i < 3; i++) chk("t4_order", log_a[i], 10 + i);
    end
    chk("t4_drained", fifo_empty, 1);

    // Simultaneous push and pop.
    nxt(); mc_valid = 1; mc_rd_a = 13; mc_rd_data = 32'hD0;
    smp(); chk("t5_c0_no_we", rf_we, 0);
    nxt(); mc_rd_a = 14; mc_rd_data = 32'hE0;
    smp();
    chk("t5_head_a", rf_a, 13);
    chk("t5_ready", mc_ready, 1);
    nxt(); mc_valid = 0;
    smp();
    chk("t5_occupied", fifo_empty, 0);
    chk("t5_next_we", rf_we, 1);
    chk("t5_next_a", rf_a, 14);
    nxt(); smp(); chk("t5_drained", fifo_empty, 1);

    // Reset mid-operation with two entries pending and starve count 3.
    nxt(); wb_rd_we = 1; wb_rd_a = 5; wb_rd_data = 32'h55;
    mc_valid = 1; mc_rd_a = 15; mc_rd_data = 32'hF0;
    smp();
    nxt(); mc_rd_a = 16; mc_rd_data = 32'hF1;
    smp();
    nxt(); mc_valid = 0;
    smp();
    nxt(); smp();
    nxt(); rst = 1;
    smp();
    chk("t6_rst_no_we", rf_we, 0);
    chk("t6_pre_rst_full", mc_ready, 0);
    nxt(); rst = 0; wb_rd_we = 0;
    smp();
    chk("t6_empty", fifo_empty, 1);
    chk("t6_ready", mc_ready, 1);
    chk("t6_no_stall", wb_stall, 0);
    for (int i = 0; i < 4; i++) begin
      nxt(); smp();
      chk("t6_no_write", rf_we, 0);
    end

    // Randomized traffic; the multi-cycle unit holds its request until accepted.
    acc = 0;
    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst        = ($urandom_range(0, 299) == 0);
      wb_rd_we   = ($urandom_range(0, 3) != 0);
      wb_rd_a    = AW'($urandom_range(0, 7));
      wb_rd_data = $urandom;
      if (!mc_valid || acc) begin
        mc_valid   = ($urandom_range(0, 2) == 0);
        mc_rd_a    = AW'($urandom_range(0, 7));
        mc_rd_data = $urandom;
      end
      smp();
      acc = mc_valid && mc_ready;
    end

    nxt();
    rst = 0;
    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
